avm_mport_arbiter: RTL and testbench

Parametrised N-port Avalon-MM arbiter that shares the single `avm_*` slave port of the SDRAM Qsys core among several masters (NEORV32 external bus, DMA, video fetch). Sits between the masters and `qsys_core` in the top level. It uses round-robin grant with one transfer per grant and waitrequest-only transfer semantics, with no readdatavalid. An optional watchdog aborts transfers that hang in the downstream core.

---
 rtl/avm_mport_arbiter_pkg.sv | 24 ++
 rtl/avm_mport_arbiter_if.sv | 43 ++++
 rtl/avm_mport_arbiter_rr_picker.sv | 30 +++
 rtl/avm_mport_arbiter.sv | 149 ++++++++++++++
 tb/tb_avm_mport_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avm_mport_arbiter_pkg.sv
// rtl/avm_mport_arbiter_pkg.sv - shared types, constants and helpers for the Avalon-MM port arbiter
package avm_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam logic [31:0] ERR_READDATA    = 32'hDEAD_BEEF;
    localparam int          DEFAULT_TIMEOUT = 1024;

    // Index width for n items, never below 1 so single-bit selects stay legal
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/avm_mport_arbiter_if.sv
// rtl/avm_mport_arbiter_if.sv - packed multi-master Avalon-MM bus plus the shared downstream slave port
interface avm_mport_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [NUM_PORTS-1:0]            m_cs_i;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] m_address_i;
    logic [NUM_PORTS-1:0]            m_read_i;
    logic [NUM_PORTS-1:0]            m_write_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] m_writedata_i;
    logic [NUM_PORTS*BE_WIDTH-1:0]   m_byteenable_i;
    logic [NUM_PORTS-1:0]            m_waitrequest_o;
    logic [NUM_PORTS*DATA_WIDTH-1:0] m_readdata_o;

    logic                            s_cs_o;
    logic                            s_read_o;
    logic                            s_write_o;
    logic [ADDR_WIDTH-1:0]           s_address_o;
    logic [DATA_WIDTH-1:0]           s_writedata_o;
    logic [BE_WIDTH-1:0]             s_byteenable_o;
    logic                            s_waitrequest_i;
    logic [DATA_WIDTH-1:0]           s_readdata_i;

    // Environment side: upstream masters and the downstream core model
    modport master (
        output m_cs_i, m_address_i, m_read_i, m_write_i, m_writedata_i, m_byteenable_i,
        output s_waitrequest_i, s_readdata_i,
        input  m_waitrequest_o, m_readdata_o,
        input  s_cs_o, s_read_o, s_write_o, s_address_o, s_writedata_o, s_byteenable_o
    );

    // Arbiter side
    modport slave (
        input  m_cs_i, m_address_i, m_read_i, m_write_i, m_writedata_i, m_byteenable_i,
        input  s_waitrequest_i, s_readdata_i,
        output m_waitrequest_o, m_readdata_o,
        output s_cs_o, s_read_o, s_write_o, s_address_o, s_writedata_o, s_byteenable_o
    );

endinterface

// File: rtl/avm_mport_arbiter_rr_picker.sv
// rtl/avm_mport_arbiter_rr_picker.sv - combinational cyclic priority select starting at a pointer
module rr_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic                 valid_o,
    output logic [IDX_W-1:0]     idx_o
);

    int j;

    // Walk offsets from far to near so the closest requester at/after ptr wins
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        j       = 0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end
            if (req_i[j]) begin
                idx_o = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/avm_mport_arbiter.sv
// rtl/avm_mport_arbiter.sv - round-robin N-master Avalon-MM arbiter; AVM_ARB_TIMEOUT_EN adds a watchdog
module avm_mport_arbiter
    import avm_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    avm_mport_arbiter_if.slave            bus,
    output logic                          timeout_o,
    output logic [clog2(NUM_PORTS)-1:0]   timeout_port_o
);

    localparam int IDX_W = clog2(NUM_PORTS);

    if (TIMEOUT_CYCLES < 4) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 4");
    end

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_next;
    logic [NUM_PORTS-1:0] req;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic                 g_req;
    logic                 done;
    logic                 to_fire;

    assign req        = bus.m_cs_i & (bus.m_read_i | bus.m_write_i);
    assign g_req      = req[grant_q];
    assign done       = (state_q == GRANT) && g_req && !bus.s_waitrequest_i;
    assign grant_next = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef AVM_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic [IDX_W-1:0] to_port_q, to_port_d;

    assign to_fire        = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign timeout_o      = to_q;
    assign timeout_port_o = to_port_q;
`else
    assign to_fire        = 1'b0;
    assign timeout_o      = 1'b0;
    assign timeout_port_o = '0;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
`ifdef AVM_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            to_q      <= 1'b0;
            to_port_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
`ifdef AVM_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            to_port_q <= to_port_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
`ifdef AVM_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        to_d      = to_q;
        to_port_d = to_port_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef AVM_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (to_fire || done) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_next;
                end else if (!g_req) begin
                    state_d = IDLE;
                end
`ifdef AVM_ARB_TIMEOUT_EN
                if (to_fire) begin
                    to_d      = 1'b1;
                    to_port_d = grant_q;
                end else if (bus.s_waitrequest_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Downstream is a combinational mux of the granted master; a watchdog abort blanks the strobes
    always_comb begin
        bus.s_cs_o          = 1'b0;
        bus.s_read_o        = 1'b0;
        bus.s_write_o       = 1'b0;
        bus.s_address_o     = '0;
        bus.s_writedata_o   = '0;
        bus.s_byteenable_o  = '0;
        bus.m_waitrequest_o = '1;
        bus.m_readdata_o    = '0;
        if (state_q == GRANT) begin
            bus.s_cs_o         = bus.m_cs_i[grant_q] && !to_fire;
            bus.s_write_o      = bus.m_write_i[grant_q] && !to_fire;
            bus.s_read_o       = bus.m_read_i[grant_q] && !bus.m_write_i[grant_q] && !to_fire;
            bus.s_address_o    = bus.m_address_i[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.s_writedata_o  = bus.m_writedata_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            bus.s_byteenable_o = bus.m_byteenable_i[int'(grant_q)*(DATA_WIDTH/8) +: (DATA_WIDTH/8)];
            bus.m_waitrequest_o[grant_q] = !(done || to_fire);
            bus.m_readdata_o[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] =
                to_fire ? DATA_WIDTH'(ERR_READDATA) : bus.s_readdata_i;
        end
    end

endmodule

// File: tb/tb_avm_mport_arbiter.sv
// tb/tb_avm_mport_arbiter.sv - directed bench with a transaction-level arbitration model checked every cycle
module tb_avm_mport_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef AVM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic timeout_o;
    logic timeout_port_o;

    int errors = 0;
    int checks = 0;

    avm_mport_arbiter_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    avm_mport_arbiter #(
        .NUM_PORTS      (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_clk        (clk),
        .reset_reset    (rst),
        .bus            (bus),
        .timeout_o      (timeout_o),
        .timeout_port_o (timeout_port_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit req_of(input int i);
        return bus.m_cs_i[i] & (bus.m_read_i[i] | bus.m_write_i[i]);
    endfunction

    // Transaction model: owner is the master holding the bus (-1 when free), nxt is where the search starts
    int owner   = -1;
    int nxt     = 0;
    int waited  = 0;
    bit to_flag = 1'b0;
    int to_port = 0;

    function automatic bit fire_now();
        return TO_EN && (owner >= 0) && (waited == TO);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner = -1; nxt = 0; waited = 0; to_flag = 1'b0; to_port = 0;
        end else if (owner < 0) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req_of((nxt + k) % N)) owner = (nxt + k) % N;
            end
            waited = 0;
        end else if (fire_now()) begin
            to_flag = 1'b1; to_port = owner; nxt = (owner + 1) % N; owner = -1;
        end else if (req_of(owner) && !bus.s_waitrequest_i) begin
            nxt = (owner + 1) % N; owner = -1;
        end else if (!req_of(owner)) begin
            owner = -1;
        end else if (bus.s_waitrequest_i) begin
            waited++;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0]    e_wait;
        logic [N*DW-1:0] e_rdata;
        logic            e_cs, e_rd, e_wr, f;
        logic [AW-1:0]   e_addr;
        logic [DW-1:0]   e_wdata;
        logic [3:0]      e_be;
        e_wait = '1; e_rdata = '0; e_cs = 0; e_rd = 0; e_wr = 0;
        e_addr = '0; e_wdata = '0; e_be = '0;
        if (owner >= 0) begin
            f       = fire_now();
            e_cs    = bus.m_cs_i[owner] && !f;
            e_wr    = bus.m_write_i[owner] && !f;
            e_rd    = bus.m_read_i[owner] && !bus.m_write_i[owner] && !f;
            e_addr  = bus.m_address_i[owner*AW +: AW];
            e_wdata = bus.m_writedata_i[owner*DW +: DW];
            e_be    = bus.m_byteenable_i[owner*4 +: 4];
            e_wait[owner] = !(f || (req_of(owner) && !bus.s_waitrequest_i));
            e_rdata[owner*DW +: DW] = f ? 32'hDEAD_BEEF : bus.s_readdata_i;
        end
        chk("m_wait", 64'(bus.m_waitrequest_o), 64'(e_wait));
        chk("m_rdata", 64'(bus.m_readdata_o), 64'(e_rdata));
        chk("s_cs", 64'(bus.s_cs_o), 64'(e_cs));
        chk("s_read", 64'(bus.s_read_o), 64'(e_rd));
        chk("s_write", 64'(bus.s_write_o), 64'(e_wr));
        chk("s_addr", 64'(bus.s_address_o), 64'(e_addr));
        chk("s_wdata", 64'(bus.s_writedata_o), 64'(e_wdata));
        chk("s_be", 64'(bus.s_byteenable_o), 64'(e_be));
        chk("timeout", 64'(timeout_o), 64'(to_flag));
        chk("timeout_port", 64'(timeout_port_o), 64'(to_port));
    end

    task automatic clear_inputs();
        bus.m_cs_i = '0; bus.m_read_i = '0; bus.m_write_i = '0;
        bus.m_address_i = '0; bus.m_writedata_i = '0; bus.m_byteenable_i = '0;
        bus.s_waitrequest_i = 1'b0; bus.s_readdata_i = '0;
    endtask

    task automatic set_m(input int i, input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        bus.m_cs_i[i] = rd | wr;
        bus.m_read_i[i] = rd;
        bus.m_write_i[i] = wr;
        bus.m_address_i[i*AW +: AW] = addr;
        bus.m_writedata_i[i*DW +: DW] = wd;
        bus.m_byteenable_i[i*4 +: 4] = 4'hF - 4'(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int q_port[$];
    int q_cyc[$];
    int hit;
    logic [31:0] hit_data;
    logic hit_sread;

    initial begin
        clear_inputs();
        @(negedge clk);
        chk("rst_wait", 64'(bus.m_waitrequest_o), 64'h3);
        chk("rst_rdata", 64'(bus.m_readdata_o), 64'h0);
        chk("rst_scs", 64'(bus.s_cs_o), 64'h0);
        chk("rst_timeout", 64'(timeout_o), 64'h0);

        // Single master read, zero wait states
        do_reset();
        set_m(0, 1, 0, 32'h0000_0100, 32'h0);
        bus.s_readdata_i = 32'h1234_5678;
        @(negedge clk);
        chk("t1_c0_sread", 64'(bus.s_read_o), 64'h0);
        chk("t1_c0_wait0", 64'(bus.m_waitrequest_o[0]), 64'h1);
        step();
        @(negedge clk);
        chk("t1_c1_sread", 64'(bus.s_read_o), 64'h1);
        chk("t1_c1_wait0", 64'(bus.m_waitrequest_o[0]), 64'h0);
        chk("t1_c1_rdata", 64'(bus.m_readdata_o[31:0]), 64'h1234_5678);
        chk("t1_c1_addr", 64'(bus.s_address_o), 64'h100);
        step();
        clear_inputs();

        // Two continuous writers alternate
        do_reset();
        set_m(0, 0, 1, 32'h10, 32'hAAAA_0000);
        set_m(1, 0, 1, 32'h20, 32'hBBBB_1111);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!bus.m_waitrequest_o[i]) begin
                    q_port.push_back(i);
                    q_cyc.push_back(c);
                end
            end
        end
        chk("t2_count", 64'(q_port.size()), 64'd4);
        for (int k = 0; k < 4 && k < q_port.size(); k++) begin
            chk("t2_port", 64'(q_port[k]), 64'(k % 2));
            chk("t2_cycle", 64'(q_cyc[k]), 64'(2 * k + 1));
        end
        step();
        clear_inputs();

        // Master 1 write with three downstream wait states
        do_reset();
        set_m(1, 0, 1, 32'h40, 32'hCAFE_F00D);
        for (int c = 0; c <= 4; c++) begin
            bus.s_waitrequest_i = (c < 4);
            @(negedge clk);
            chk("t3_wait1", 64'(bus.m_waitrequest_o[1]), 64'(c != 4));
            chk("t3_wait0", 64'(bus.m_waitrequest_o[0]), 64'h1);
            step();
        end
        clear_inputs();

        // Read and write together is a write
        do_reset();
        set_m(0, 1, 1, 32'h80, 32'h5555_AAAA);
        step();
        @(negedge clk);
        chk("t4_swrite", 64'(bus.s_write_o), 64'h1);
        chk("t4_sread", 64'(bus.s_read_o), 64'h0);
        chk("t4_wdata", 64'(bus.s_writedata_o), 64'h5555_AAAA);
        step();
        clear_inputs();

        // Dropped request leaves the pointer alone
        do_reset();
        set_m(0, 1, 0, 32'h4, 32'h0);
        step();
        clear_inputs();
        @(negedge clk);
        chk("t6_drop_wait0", 64'(bus.m_waitrequest_o[0]), 64'h1);
        step();
        set_m(0, 1, 0, 32'h4, 32'h0);
        set_m(1, 1, 0, 32'h8, 32'h0);
        step();
        @(negedge clk);
        chk("t6_regrant0", 64'(bus.m_waitrequest_o), 64'h2);
        step();
        clear_inputs();

        // Reset mid-transfer, then arbitration restarts at master 0
        do_reset();
        set_m(0, 1, 0, 32'h4, 32'h0);
        step();
        step();
        clear_inputs();
        set_m(1, 1, 0, 32'hC, 32'h0);
        bus.s_waitrequest_i = 1'b1;
        step();
        @(negedge clk);
        chk("t5_pre_sread", 64'(bus.s_read_o), 64'h1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_scs", 64'(bus.s_cs_o), 64'h0);
        chk("t5_rst_sread", 64'(bus.s_read_o), 64'h0);
        chk("t5_rst_addr", 64'(bus.s_address_o), 64'h0);
        chk("t5_rst_wait", 64'(bus.m_waitrequest_o), 64'h3);
        set_m(0, 1, 0, 32'h4, 32'h0);
        bus.s_waitrequest_i = 1'b0;
        #1 rst = 1'b0;
        step();
        @(negedge clk);
        chk("t5_resume_wait", 64'(bus.m_waitrequest_o), 64'h2);
        step();
        clear_inputs();

`ifdef AVM_ARB_TIMEOUT_EN
        // Downstream stuck on a master 1 read
        do_reset();
        set_m(1, 1, 0, 32'h200, 32'h0);
        bus.s_waitrequest_i = 1'b1;
        hit = -1; hit_data = '0; hit_sread = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (hit < 0 && !bus.m_waitrequest_o[1]) begin
                hit = c;
                hit_data = bus.m_readdata_o[63:32];
                hit_sread = bus.s_read_o;
            end
            step();
        end
        chk("to_cycle", 64'(hit), 64'd9);
        chk("to_rdata", 64'(hit_data), 64'hDEAD_BEEF);
        chk("to_sread", 64'(hit_sread), 64'h0);
        chk("to_flag", 64'(timeout_o), 64'h1);
        chk("to_port", 64'(timeout_port_o), 64'h1);
        clear_inputs();
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
